exec_muldiv_seq: RTL and testbench

- Multi-cycle sequencer for MUL/DIV in the execute stage. It time-shares the existing 16-bit exec ALU to do 16x16->32 multiply (shift-add) and 32/16 divide (restoring).
- It drives the ALU's function, operand and carry inputs every cycle and consumes its 17-bit result. This lets the execute unit run 8086 MUL/DIV without a dedicated multiplier or divider.
- While oBusy=1 the execute stage must not use the ALU.

---
 rtl/exec_muldiv_seq.sv | 229 ++++++++++++++++++++++
 tb/tb_exec_muldiv_seq.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/exec_muldiv_seq.sv
// exec_muldiv_seq
// Multi-cycle MUL/DIV sequencer for the execute stage. It borrows the
// shared 16-bit exec ALU one iteration per cycle: shift-add for the
// 16x16->32 multiply and restoring division for 32/16 divide.
//
// Ports:
//   iClk, iRst_n          clock (rising edge), asynchronous active-low reset
//   iStart, iOp           start request (sampled in IDLE), 0=MUL 1=DIV
//   iOpHi, iOpLo, iOpB    DX / AX / multiplier-or-divisor
//   iSigned               IMUL/IDIV select (only with EXEC_MULDIV_SIGNED_EN)
//   iFlush                synchronous abort back to IDLE
//   oAluFunc/R1/R2/Carry  drive to the shared ALU (combinational from state)
//   iAluResult            17-bit ALU result, bit16 = carry / borrow
//   oBusy                 ALU is owned by this block
//   oDone, oDivErr        one-cycle completion pulse and divide error flag
//   oResHi, oResLo        product hi/lo, or remainder/quotient
//
// Optional feature macro: EXEC_MULDIV_SIGNED_EN (signed ops, PRE/POST
// states, 19-cycle latency). Undefined: unsigned only, 17-cycle latency.
module exec_muldiv_seq (
  input  logic        iClk,
  input  logic        iRst_n,
  input  logic        iStart,
  input  logic        iOp,
  input  logic [15:0] iOpHi,
  input  logic [15:0] iOpLo,
  input  logic [15:0] iOpB,
`ifdef EXEC_MULDIV_SIGNED_EN
  input  logic        iSigned,
`endif
  input  logic        iFlush,
  output logic [3:0]  oAluFunc,
  output logic [15:0] oAluR1,
  output logic [15:0] oAluR2,
  output logic        oAluCarry,
  input  logic [16:0] iAluResult,
  output logic        oBusy,
  output logic        oDone,
  output logic        oDivErr,
  output logic [15:0] oResHi,
  output logic [15:0] oResLo
);

  localparam logic [3:0] FN_ADD  = 4'b0000;
  localparam logic [3:0] FN_SUB  = 4'b0101;
  localparam logic [3:0] FN_PASS = 4'b1101;

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_CALC, S_POST, S_DONE} state_t;

  state_t      state_q;
  logic [4:0]  cnt_q;
  logic        op_q;
  logic [15:0] p_q;      // MUL high accumulator / DIV partial remainder
  logic [15:0] q_q;      // MUL multiplier shift reg / DIV quotient shift reg
  logic [15:0] b_q;
  logic        done_q, err_q;
  logic [15:0] res_hi_q, res_lo_q;

  logic [16:0] t_w;
  logic        qbit_w;
  logic [15:0] p_d, q_d;
  logic [3:0]  alu_func;
  logic [15:0] alu_r1, alu_r2;

`ifdef EXEC_MULDIV_SIGNED_EN
  logic        sgn_q, neg_q, rneg_q;
  logic [31:0] dvd_neg, prod_neg;
  logic [15:0] lo_neg, b_mag, div_hi_mag, quo_neg, rem_neg;
  logic        quo_ovf;

  // Magnitudes are formed locally so the ALU stays free for the iterations.
  assign dvd_neg    = 32'd0 - {p_q, q_q};
  assign prod_neg   = dvd_neg;
  assign lo_neg     = 16'd0 - q_q;
  assign b_mag      = (sgn_q && b_q[15]) ? (16'd0 - b_q) : b_q;
  assign div_hi_mag = (sgn_q && p_q[15]) ? dvd_neg[31:16] : p_q;
  assign quo_neg    = 16'd0 - q_q;
  assign rem_neg    = 16'd0 - p_q;
  assign quo_ovf    = sgn_q && (neg_q ? (q_q > 16'h8000) : (q_q > 16'h7FFF));
  assign oBusy      = (state_q == S_PRE) || (state_q == S_CALC) || (state_q == S_POST);
`else
  assign oBusy      = (state_q == S_CALC);
`endif

  // One iteration: the ALU result is consumed in the cycle it is produced.
  always_comb begin
    alu_func = FN_PASS;
    alu_r1   = 16'h0;
    alu_r2   = 16'h0;
    p_d      = p_q;
    q_d      = q_q;
    t_w      = {p_q, q_q[15]};
    qbit_w   = 1'b0;
    if (state_q == S_CALC) begin
      if (!op_q) begin
        alu_r1 = p_q;
        if (q_q[0]) begin
          alu_func = FN_ADD;
          alu_r2   = b_q;
        end
        // 33-bit right shift keeps the add carry as the new P[15].
        {p_d, q_d} = {iAluResult, q_q[15:1]};
      end else begin
        alu_func = FN_SUB;
        alu_r1   = t_w[15:0];
        alu_r2   = b_q;
        // T[16] set means T >= B even when the 16-bit subtract borrows.
        qbit_w   = t_w[16] | ~iAluResult[16];
        p_d      = qbit_w ? iAluResult[15:0] : t_w[15:0];
        q_d      = {q_q[14:0], qbit_w};
      end
    end
  end

  assign oAluFunc  = alu_func;
  assign oAluR1    = alu_r1;
  assign oAluR2    = alu_r2;
  assign oAluCarry = 1'b0;
  assign oDone     = done_q;
  assign oDivErr   = err_q;
  assign oResHi    = res_hi_q;
  assign oResLo    = res_lo_q;

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= 5'd0;
      op_q     <= 1'b0;
      p_q      <= 16'h0;
      q_q      <= 16'h0;
      b_q      <= 16'h0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      res_hi_q <= 16'h0;
      res_lo_q <= 16'h0;
`ifdef EXEC_MULDIV_SIGNED_EN
      sgn_q    <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
`endif
    end else if (iFlush) begin
      state_q <= S_IDLE;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (iStart) begin
            op_q  <= iOp;
            b_q   <= iOpB;
            q_q   <= iOpLo;
            p_q   <= iOp ? iOpHi : 16'h0;
            cnt_q <= 5'd0;
`ifdef EXEC_MULDIV_SIGNED_EN
            sgn_q   <= iSigned;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            state_q <= S_PRE;
`else
            // High word >= divisor means the quotient cannot fit 16 bits.
            if (iOp && (iOpHi >= iOpB)) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else begin
              state_q <= S_CALC;
            end
`endif
          end
        end
`ifdef EXEC_MULDIV_SIGNED_EN
        S_PRE: begin
          if (sgn_q) begin
            neg_q  <= (op_q ? p_q[15] : q_q[15]) ^ b_q[15];
            rneg_q <= op_q & p_q[15];
            b_q    <= b_mag;
            if (op_q) begin
              if (p_q[15]) {p_q, q_q} <= dvd_neg;
            end else if (q_q[15]) begin
              q_q <= lo_neg;
            end
          end
          if (op_q && (div_hi_mag >= b_mag)) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
          end else begin
            state_q <= S_CALC;
          end
        end
`endif
        S_CALC: begin
          p_q   <= p_d;
          q_q   <= q_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd15) begin
`ifdef EXEC_MULDIV_SIGNED_EN
            state_q <= S_POST;
`else
            state_q  <= S_DONE;
            done_q   <= 1'b1;
            res_hi_q <= p_d;
            res_lo_q <= q_d;
`endif
          end
        end
`ifdef EXEC_MULDIV_SIGNED_EN
        S_POST: begin
          state_q <= S_DONE;
          done_q  <= 1'b1;
          if (!op_q) begin
            {res_hi_q, res_lo_q} <= neg_q ? prod_neg : {p_q, q_q};
          end else if (quo_ovf) begin
            err_q <= 1'b1;
          end else begin
            res_lo_q <= neg_q ? quo_neg : q_q;
            res_hi_q <= rneg_q ? rem_neg : p_q;
          end
        end
`endif
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_muldiv_seq.sv
// Testbench for exec_muldiv_seq: behavioural ALU, arithmetic reference
// model, per-cycle compare process and literal checks on the test-plan ops.
module tb_exec_muldiv_seq;

`ifdef EXEC_MULDIV_SIGNED_EN
  localparam int LAT = 19;
  localparam int ERRLAT = 2;
`else
  localparam int LAT = 17;
  localparam int ERRLAT = 1;
`endif

  logic        iClk, iRst_n, iStart, iOp, iFlush;
  logic [15:0] iOpHi, iOpLo, iOpB;
  logic [3:0]  oAluFunc;
  logic [15:0] oAluR1, oAluR2;
  logic        oAluCarry;
  logic [16:0] iAluResult;
  logic        oBusy, oDone, oDivErr;
  logic [15:0] oResHi, oResLo;
`ifdef EXEC_MULDIV_SIGNED_EN
  logic        iSigned;
  initial iSigned = 1'b0;
`endif

  exec_muldiv_seq dut (
    .iClk(iClk), .iRst_n(iRst_n), .iStart(iStart), .iOp(iOp),
    .iOpHi(iOpHi), .iOpLo(iOpLo), .iOpB(iOpB),
`ifdef EXEC_MULDIV_SIGNED_EN
    .iSigned(iSigned),
`endif
    .iFlush(iFlush),
    .oAluFunc(oAluFunc), .oAluR1(oAluR1), .oAluR2(oAluR2), .oAluCarry(oAluCarry),
    .iAluResult(iAluResult),
    .oBusy(oBusy), .oDone(oDone), .oDivErr(oDivErr),
    .oResHi(oResHi), .oResLo(oResLo)
  );

  // Shared exec ALU, behavioural.
  always_comb begin
    case (oAluFunc)
      4'b0000: iAluResult = {1'b0, oAluR1} + {1'b0, oAluR2} + {16'h0, oAluCarry};
      4'b0101: iAluResult = {1'b0, oAluR1} - {1'b0, oAluR2} - {16'h0, oAluCarry};
      4'b1101: iAluResult = {1'b0, oAluR1};
      default: iAluResult = 17'h0;
    endcase
  end

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int c0 = 0;
  int exp_done_cyc = -1;
  int busy_lo = 1, busy_hi = 0;
  bit exp_err = 1'b0;
  logic [15:0] exp_phi = 16'h0, exp_plo = 16'h0;   // result of op in flight
  logic [15:0] m_hi = 16'h0, m_lo = 16'h0;         // expected result registers
  bit cur_op;
  logic [15:0] cur_hi, cur_lo, cur_b;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, got, exp, cyc);
  endtask

  // Reference: plain arithmetic on the architectural operands.
  function automatic void model(input bit op, input logic [15:0] hi, lo, b,
                                output bit err, output logic [15:0] rh, rl);
    logic [31:0] prod, dvd, quo, rem;
    err = 1'b0; rh = 16'h0; rl = 16'h0;
    if (!op) begin
      prod = {16'h0, lo} * {16'h0, b};
      rh = prod[31:16]; rl = prod[15:0];
    end else begin
      dvd = {hi, lo};
      if (b == 16'h0) err = 1'b1;
      else begin
        quo = dvd / {16'h0, b};
        rem = dvd % {16'h0, b};
        if (quo > 32'h0000_FFFF) err = 1'b1;
        else begin rl = quo[15:0]; rh = rem[15:0]; end
      end
    end
  endfunction

  // Compare process: every cycle, shortly after the rising edge.
  initial begin
    bit exp_d;
    forever begin
      @(posedge iClk);
      cyc++;
      #2;
      if (iRst_n) begin
        exp_d = (cyc == exp_done_cyc);
        if (exp_d && !exp_err) begin m_hi = exp_phi; m_lo = exp_plo; end
        chk("done", 32'(oDone), 32'(exp_d));
        chk("busy", 32'(oBusy), 32'(cyc >= busy_lo && cyc <= busy_hi));
        if (exp_d) chk("diverr", 32'(oDivErr), 32'(exp_err));
        chk("res_hi", 32'(oResHi), 32'(m_hi));
        chk("res_lo", 32'(oResLo), 32'(m_lo));
        chk("carry_in", 32'(oAluCarry), 32'h0);
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_func"}, 32'(oAluFunc), 32'h0000_000D);
    chk({tag, "_r1"}, 32'(oAluR1), 32'h0);
    chk({tag, "_r2"}, 32'(oAluR2), 32'h0);
    chk({tag, "_busy"}, 32'(oBusy), 32'h0);
    chk({tag, "_done"}, 32'(oDone), 32'h0);
    chk({tag, "_err"}, 32'(oDivErr), 32'h0);
    chk({tag, "_hi"}, 32'(oResHi), 32'h0);
    chk({tag, "_lo"}, 32'(oResLo), 32'h0);
  endtask

  // Called at a falling edge; iStart is high for exactly one cycle (cycle 0).
  task automatic start_op(input bit op, input logic [15:0] hi, lo, b);
    bit err;
    logic [15:0] rh, rl;
    model(op, hi, lo, b, err, rh, rl);
    cur_op = op; cur_hi = hi; cur_lo = lo; cur_b = b;
    iStart = 1'b1; iOp = op; iOpHi = hi; iOpLo = lo; iOpB = b;
    c0 = cyc;
    exp_err = err; exp_phi = rh; exp_plo = rl;
    exp_done_cyc = c0 + (err ? ERRLAT : LAT);
    busy_lo = c0 + 1;
    busy_hi = exp_done_cyc - 1;
    @(negedge iClk);
    iStart = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    while (cyc <= exp_done_cyc) @(negedge iClk);
    $display("[%0d] %s op=%0d hi=%h lo=%h b=%h -> exp err=%0d res=%h:%h dut=%h:%h",
             cyc, tag, cur_op, cur_hi, cur_lo, cur_b, exp_err, m_hi, m_lo, oResHi, oResLo);
  endtask

  task automatic run_op(input bit op, input logic [15:0] hi, lo, b, input string tag);
    start_op(op, hi, lo, b);
    wait_done(tag);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rb, rhi, rlo;
    bit rop;
    iRst_n = 1'b0; iStart = 1'b0; iOp = 1'b0; iFlush = 1'b0;
    iOpHi = 16'h0; iOpLo = 16'h0; iOpB = 16'h0;
    #12;
    check_reset_outputs("por");
    @(negedge iClk);
    iRst_n = 1'b1;
    @(negedge iClk);

    // Test-plan operations with literal expectations.
    run_op(1'b0, 16'h0000, 16'h1234, 16'h0100, "mul_1234x0100");
    chk("mul1_hi", 32'(oResHi), 32'h0012);
    chk("mul1_lo", 32'(oResLo), 32'h3400);
    run_op(1'b0, 16'h0000, 16'hFFFF, 16'hFFFF, "mul_ffffxffff");
    chk("mul2_hi", 32'(oResHi), 32'hFFFE);
    chk("mul2_lo", 32'(oResLo), 32'h0001);
    run_op(1'b1, 16'h0001, 16'h0000, 16'h0010, "div_10000/10");
    chk("div1_quo", 32'(oResLo), 32'h1000);
    chk("div1_rem", 32'(oResHi), 32'h0000);
    run_op(1'b1, 16'h0000, 16'h0064, 16'h0007, "div_64/7");
    chk("div2_quo", 32'(oResLo), 32'h000E);
    chk("div2_rem", 32'(oResHi), 32'h0002);
    run_op(1'b1, 16'h1234, 16'h5678, 16'h0000, "div_by_zero");
    chk("dz_keep_hi", 32'(oResHi), 32'h0002);
    chk("dz_keep_lo", 32'(oResLo), 32'h000E);
    run_op(1'b1, 16'h0010, 16'h0000, 16'h0010, "div_overflow");
    chk("ovf_keep_hi", 32'(oResHi), 32'h0002);
    chk("ovf_keep_lo", 32'(oResLo), 32'h000E);

    // iStart during a running MUL is ignored.
    start_op(1'b0, 16'h0000, 16'h00FF, 16'h0101);
    while (cyc < c0 + 5) @(negedge iClk);
    iStart = 1'b1; iOp = 1'b1; iOpHi = 16'h0000; iOpLo = 16'h0009; iOpB = 16'h0003;
    @(negedge iClk);
    iStart = 1'b0;
    wait_done("mul_start_ignored");
    chk("ign_hi", 32'(oResHi), 32'h0000);
    chk("ign_lo", 32'(oResLo), 32'hFFFF);

    // Flush at cycle 8: back to IDLE, no completion, results kept.
    start_op(1'b0, 16'h0000, 16'h0007, 16'h0009);
    while (cyc < c0 + 8) @(negedge iClk);
    iFlush = 1'b1;
    exp_done_cyc = -1;
    busy_hi = c0 + 8;
    @(negedge iClk);
    iFlush = 1'b0;
    repeat (20) @(negedge iClk);
    $display("[%0d] flush at cycle 8 of mul, results %h:%h", cyc, oResHi, oResLo);

    // Reset mid-operation takes effect without a clock edge.
    start_op(1'b1, 16'h0000, 16'h1000, 16'h0003);
    while (cyc < c0 + 6) @(negedge iClk);
    iRst_n = 1'b0;
    exp_done_cyc = -1;
    busy_lo = 1; busy_hi = 0;
    m_hi = 16'h0; m_lo = 16'h0;
    #1;
    check_reset_outputs("midrst");
    $display("[%0d] async reset during div", cyc);
    @(negedge iClk);
    iRst_n = 1'b1;
    @(negedge iClk);

    // Randomized back-to-back traffic, mostly non-overflowing divides.
    for (int n = 0; n < 150; n++) begin
      rop = 1'($urandom_range(0, 1));
      rb  = 16'($urandom);
      if ($urandom_range(0, 7) == 0) rb = 16'($urandom_range(0, 3));
      rlo = 16'($urandom);
      if ($urandom_range(0, 3) == 0 || rb == 16'h0) rhi = 16'($urandom);
      else rhi = 16'($urandom) % rb;
      run_op(rop, rhi, rlo, rb, "rand");
      repeat ($urandom_range(0, 2)) @(negedge iClk);
    end

    repeat (3) @(negedge iClk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
